// File: rtl/ctrl_packet_initiator.sv
// Host-side control packet initiator: injects one write/read-request packet into an idle
// upstream slot and, for reads, waits for the matching read response or a timeout.
module ctrl_packet_initiator #(
  parameter int DATA_WIDTH                  = 512,
  parameter int STREAM_ID_NUM               = 16,
  parameter int CHUNK_ID_NUM                = 32,
  parameter int CHANNEL_ID_NUM              = 1024,
  parameter int STATE_WIDTH                 = 32,
  parameter int CTRL_STREAM_ID              = 0,
  parameter int CP_R_CTRL_READ_REQUEST_32b  = 0,
  parameter int CP_R_CTRL_WRITE_32b         = 1,
  parameter int CP_A_CTRL_READ_RESPONSE_32b = 1,
  parameter int TIMEOUT_CYCLES              = 1024,
  localparam int STREAM_ID_WIDTH  = $clog2(STREAM_ID_NUM),
  localparam int CHUNK_ID_WIDTH   = $clog2(CHUNK_ID_NUM),
  localparam int CHANNEL_ID_WIDTH = $clog2(CHANNEL_ID_NUM)
) (
  input  logic                        clk,
  input  logic                        rstnIn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [CHANNEL_ID_WIDTH-1:0] cmd_hop,
  input  logic [STATE_WIDTH-1:0]      cmd_addr,
  input  logic [31:0]                 cmd_wdata,
  output logic                        rsp_valid,
  output logic                        rsp_timeout,
  output logic [31:0]                 rsp_data,
  input  logic [DATA_WIDTH-1:0]       Up_Data,
  input  logic [1:0]                  Up_Type,
  input  logic                        Up_Last,
  input  logic [STREAM_ID_WIDTH-1:0]  Up_StreamID,
  input  logic [CHUNK_ID_WIDTH-1:0]   Up_ChunkID,
  input  logic [CHANNEL_ID_WIDTH-1:0] Up_ChannelID,
  input  logic [STATE_WIDTH-1:0]      Up_State,
  output logic [DATA_WIDTH-1:0]       Down_Data,
  output logic [1:0]                  Down_Type,
  output logic                        Down_Last,
  output logic [STREAM_ID_WIDTH-1:0]  Down_StreamID,
  output logic [CHUNK_ID_WIDTH-1:0]   Down_ChunkID,
  output logic [CHANNEL_ID_WIDTH-1:0] Down_ChannelID,
  output logic [STATE_WIDTH-1:0]      Down_State,
  input  logic [DATA_WIDTH-1:0]       Ret_Data,
  input  logic [1:0]                  Ret_Type,
  input  logic [CHUNK_ID_WIDTH-1:0]   Ret_ChunkID,
  input  logic [STATE_WIDTH-1:0]      Ret_State
);

  localparam int NUM_WORDS = DATA_WIDTH / 32;
  localparam int CNT_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CHUNK_ID_WIDTH-1:0] CHUNK_WR  =
    {1'b1, (CHUNK_ID_WIDTH-1)'(CP_R_CTRL_WRITE_32b)};
  localparam logic [CHUNK_ID_WIDTH-1:0] CHUNK_RD  =
    {1'b1, (CHUNK_ID_WIDTH-1)'(CP_R_CTRL_READ_REQUEST_32b)};
  localparam logic [CHUNK_ID_WIDTH-1:0] CHUNK_RSP =
    {1'b0, (CHUNK_ID_WIDTH-1)'(CP_A_CTRL_READ_RESPONSE_32b)};
  localparam logic [STREAM_ID_WIDTH-1:0] CTRL_SID = STREAM_ID_WIDTH'(CTRL_STREAM_ID);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_e;

  typedef struct packed {
    logic                        write;
    logic [CHANNEL_ID_WIDTH-1:0] hop;
    logic [STATE_WIDTH-1:0]      addr;
    logic [31:0]                 wdata;
  } cmd_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]       data;
    logic [1:0]                  ptype;
    logic                        last;
    logic [STREAM_ID_WIDTH-1:0]  sid;
    logic [CHUNK_ID_WIDTH-1:0]   ckid;
    logic [CHANNEL_ID_WIDTH-1:0] chid;
    logic [STATE_WIDTH-1:0]      state;
  } pkt_t;

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  pkt_t              down_q, down_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              alive_q;

  pkt_t                  up_pkt, inj_pkt;
  logic [DATA_WIDTH-1:0] wr_fill;
  logic                  ret_match;
  logic                  unused_ret;

  assign up_pkt = {Up_Data, Up_Type, Up_Last, Up_StreamID, Up_ChunkID, Up_ChannelID, Up_State};

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_fill
    assign wr_fill[g*32 +: 32] = cmd_q.wdata;
  end

  assign inj_pkt = {(cmd_q.write ? wr_fill : {DATA_WIDTH{1'b0}}), 2'b10, 1'b1, CTRL_SID,
                    (cmd_q.write ? CHUNK_WR : CHUNK_RD), cmd_q.hop, cmd_q.addr};

  // Only control-type read responses for the outstanding address complete a read.
  assign ret_match  = Ret_Type[1] && (Ret_ChunkID == CHUNK_RSP) && (Ret_State == cmd_q.addr);
  assign unused_ret = ^{Ret_Data[DATA_WIDTH-1:32], Ret_Type[0]};

  // alive_q holds cmd_ready low until the first clock edge after reset release.
  assign cmd_ready = alive_q && (state_q == IDLE);

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    cnt_d         = cnt_q;
    down_d        = up_pkt;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_data_d    = '0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && alive_q) begin
          cmd_d   = '{write: cmd_write, hop: cmd_hop, addr: cmd_addr, wdata: cmd_wdata};
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (Up_Type == 2'b00) begin
          down_d = inj_pkt;
          cnt_d  = '0;
          if (cmd_q.write) begin
            rsp_valid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        if (ret_match) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = Ret_Data[31:0];
          cnt_d       = '0;
          state_d     = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          cnt_d         = '0;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstnIn) begin
    if (!rstnIn) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      down_q        <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_data_q    <= '0;
      alive_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      down_q        <= down_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_data_q    <= rsp_data_d;
      alive_q       <= 1'b1;
    end
  end

  assign Down_Data      = down_q.data;
  assign Down_Type      = down_q.ptype;
  assign Down_Last      = down_q.last;
  assign Down_StreamID  = down_q.sid;
  assign Down_ChunkID   = down_q.ckid;
  assign Down_ChannelID = down_q.chid;
  assign Down_State     = down_q.state;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_timeout    = rsp_timeout_q;
  assign rsp_data       = rsp_data_q;

endmodule

// File: tb/tb_ctrl_packet_initiator.sv
// Bench for ctrl_packet_initiator: directed table, hand-written corner sequences and
// random traffic, all checked against a transaction-level reference model.
module tb_ctrl_packet_initiator;
  localparam int DW = 512, NW = 16, SIDW = 4, CKW = 5, CHW = 10, STW = 32, TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rstnIn, cmd_valid, cmd_ready, cmd_write;
  logic [CHW-1:0]  cmd_hop;
  logic [STW-1:0]  cmd_addr;
  logic [31:0]     cmd_wdata;
  logic            rsp_valid, rsp_timeout;
  logic [31:0]     rsp_data;
  logic [DW-1:0]   Up_Data, Down_Data, Ret_Data;
  logic [1:0]      Up_Type, Down_Type, Ret_Type;
  logic            Up_Last, Down_Last;
  logic [SIDW-1:0] Up_StreamID, Down_StreamID;
  logic [CKW-1:0]  Up_ChunkID, Down_ChunkID, Ret_ChunkID;
  logic [CHW-1:0]  Up_ChannelID, Down_ChannelID;
  logic [STW-1:0]  Up_State, Down_State, Ret_State;

  ctrl_packet_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstnIn(rstnIn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_hop(cmd_hop), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_timeout(rsp_timeout), .rsp_data(rsp_data),
    .Up_Data(Up_Data), .Up_Type(Up_Type), .Up_Last(Up_Last), .Up_StreamID(Up_StreamID),
    .Up_ChunkID(Up_ChunkID), .Up_ChannelID(Up_ChannelID), .Up_State(Up_State),
    .Down_Data(Down_Data), .Down_Type(Down_Type), .Down_Last(Down_Last),
    .Down_StreamID(Down_StreamID), .Down_ChunkID(Down_ChunkID),
    .Down_ChannelID(Down_ChannelID), .Down_State(Down_State),
    .Ret_Data(Ret_Data), .Ret_Type(Ret_Type), .Ret_ChunkID(Ret_ChunkID), .Ret_State(Ret_State)
  );

  typedef struct {
    logic           w;
    logic [CHW-1:0] hop;
    logic [STW-1:0] addr;
    logic [31:0]    wdata;
    logic [CKW-1:0] exp_ck;
    logic [31:0]    exp_word;
  } vec_t;
  vec_t vecs[4];

  int total = 0, bad = 0;

  // Reference model: pending/waiting command plus an absolute deadline cycle.
  bit             m_alive, m_pend, m_wait;
  int             m_deadline, cyc;
  logic           m_w;
  logic [CHW-1:0] m_hop;
  logic [STW-1:0] m_addr;
  logic [31:0]    m_wdata;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] fill(input logic [31:0] w);
    logic [DW-1:0] d;
    for (int k = 0; k < NW; k++) d[k*32 +: 32] = w;
    return d;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int k = 0; k < NW; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic set_up(input logic [1:0] t);
    Up_Type = t; Up_Last = 1'($urandom); Up_StreamID = SIDW'($urandom);
    Up_ChunkID = CKW'($urandom); Up_ChannelID = CHW'($urandom); Up_State = $urandom;
    Up_Data = rnd_data();
  endtask

  task automatic set_ret(input logic [1:0] t, input logic [CKW-1:0] ck, input logic [STW-1:0] st,
                         input logic [31:0] lo);
    Ret_Type = t; Ret_ChunkID = ck; Ret_State = st;
    Ret_Data = rnd_data(); Ret_Data[31:0] = lo;
  endtask

  // One clock: model consumes the inputs seen at the edge, DUT outputs checked 1ns later.
  task automatic tick();
    logic s_rst, s_cv, s_cw;
    logic [CHW-1:0] s_hop; logic [STW-1:0] s_addr; logic [31:0] s_wd;
    logic [DW-1:0] s_ud; logic [1:0] s_ut; logic s_ul; logic [SIDW-1:0] s_us;
    logic [CKW-1:0] s_uc; logic [CHW-1:0] s_uch; logic [STW-1:0] s_ust;
    logic [DW-1:0] s_rd; logic [1:0] s_rt; logic [CKW-1:0] s_rc; logic [STW-1:0] s_rs;
    logic [DW-1:0] e_data; logic [1:0] e_type; logic e_last; logic [SIDW-1:0] e_sid;
    logic [CKW-1:0] e_ck; logic [CHW-1:0] e_ch; logic [STW-1:0] e_st;
    logic e_rv, e_rt, e_rdy; logic [31:0] e_rd;
    s_rst = rstnIn; s_cv = cmd_valid; s_cw = cmd_write; s_hop = cmd_hop; s_addr = cmd_addr;
    s_wd = cmd_wdata; s_ud = Up_Data; s_ut = Up_Type; s_ul = Up_Last; s_us = Up_StreamID;
    s_uc = Up_ChunkID; s_uch = Up_ChannelID; s_ust = Up_State;
    s_rd = Ret_Data; s_rt = Ret_Type; s_rc = Ret_ChunkID; s_rs = Ret_State;
    @(posedge clk);
    cyc++;
    e_rv = 1'b0; e_rt = 1'b0; e_rd = '0;
    {e_data, e_type, e_last, e_sid, e_ck, e_ch, e_st} = {s_ud, s_ut, s_ul, s_us, s_uc, s_uch, s_ust};
    if (!s_rst) begin
      {e_data, e_type, e_last, e_sid, e_ck, e_ch, e_st} = '0;
      m_alive = 0; m_pend = 0; m_wait = 0; e_rdy = 1'b0;
    end else begin
      if (m_wait) begin
        if (s_rt[1] && s_rc == 5'b00001 && s_rs == m_addr) begin
          e_rv = 1'b1; e_rd = s_rd[31:0]; m_wait = 0;
        end else if (cyc == m_deadline) begin
          e_rv = 1'b1; e_rt = 1'b1; m_wait = 0;
        end
      end else if (m_pend) begin
        if (s_ut == 2'b00) begin
          e_data = m_w ? fill(m_wdata) : '0;
          e_type = 2'b10; e_last = 1'b1; e_sid = '0;
          e_ck = m_w ? 5'b10001 : 5'b10000; e_ch = m_hop; e_st = m_addr;
          m_pend = 0;
          if (m_w) e_rv = 1'b1;
          else begin m_wait = 1; m_deadline = cyc + TO; end
        end
      end else if (m_alive && s_cv) begin
        m_pend = 1; m_w = s_cw; m_hop = s_hop; m_addr = s_addr; m_wdata = s_wd;
      end
      m_alive = 1;
      e_rdy = !m_pend && !m_wait;
    end
    #1;
    chk("down_data", Down_Data, e_data);
    chk("down_hdr", DW'({Down_Type, Down_Last, Down_StreamID, Down_ChunkID, Down_ChannelID, Down_State}),
        DW'({e_type, e_last, e_sid, e_ck, e_ch, e_st}));
    chk("rsp", DW'({rsp_valid, rsp_timeout, rsp_data}), DW'({e_rv, e_rt, e_rd}));
    chk("cmd_ready", DW'(cmd_ready), DW'(e_rdy));
  endtask

  // Host holds the command until accepted; returns just after the accepting edge.
  task automatic issue(input logic w, input logic [CHW-1:0] h, input logic [STW-1:0] a,
                       input logic [31:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_hop = h; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    total++;
    if (!cmd_ready) begin bad++; $display("FAIL issue_ready act=0 exp=1 after %0d cycles", n); end
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    bit acc;
    logic [STW-1:0] addrs [3];
    vecs[0] = '{1'b1, 10'd3,    32'h10,       32'hA5A5A5A5, 5'b10001, 32'hA5A5A5A5};
    vecs[1] = '{1'b1, 10'd1023, 32'hFFFFFFFF, 32'h00000001, 5'b10001, 32'h00000001};
    vecs[2] = '{1'b0, 10'd7,    32'h44,       32'hDEADBEEF, 5'b10000, 32'h00000000};
    vecs[3] = '{1'b1, 10'd0,    32'h0,        32'h5A5A0F0F, 5'b10001, 32'h5A5A0F0F};
    addrs = '{32'h100, 32'h104, 32'h108};
    cyc = 0; m_alive = 0; m_pend = 0; m_wait = 0; m_deadline = 0;
    m_w = 0; m_hop = '0; m_addr = '0; m_wdata = '0;
    rstnIn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_hop = '0; cmd_addr = '0; cmd_wdata = '0;
    set_up(2'b00);
    set_ret(2'b00, '0, '0, '0);
    repeat (2) tick();
    chk("reset_ready", DW'(cmd_ready), DW'(1'b0));
    chk("reset_type", DW'(Down_Type), DW'(2'b00));
    chk("reset_rsp", DW'(rsp_valid), DW'(1'b0));
    rstnIn = 1'b1;
    tick();

    // Directed table: one injection per entry with Up idle.
    for (int i = 0; i < 4; i++) begin
      set_up(2'b00);
      issue(vecs[i].w, vecs[i].hop, vecs[i].addr, vecs[i].wdata);
      tick();
      chk("tbl_type", DW'({Down_Type, Down_Last}), DW'({2'b10, 1'b1}));
      chk("tbl_chunk", DW'(Down_ChunkID), DW'(vecs[i].exp_ck));
      chk("tbl_chan", DW'(Down_ChannelID), DW'(vecs[i].hop));
      chk("tbl_state", DW'(Down_State), DW'(vecs[i].addr));
      chk("tbl_data", Down_Data, fill(vecs[i].exp_word));
      chk("tbl_rsp", DW'(rsp_valid), DW'(vecs[i].w));
      if (!vecs[i].w) begin
        repeat (TO) tick();
        chk("tbl_timeout", DW'({rsp_valid, rsp_timeout}), DW'(2'b11));
      end
    end

    // Busy upstream delays injection; upstream passes at 1-cycle latency.
    set_up(2'b00);
    issue(1'b0, 10'd0, 32'h20, 32'h0);
    for (int k = 0; k < 3; k++) begin
      set_up(2'b01);
      tick();
      chk("busy_pass", DW'(Down_Type), DW'(2'b01));
    end
    set_up(2'b00);
    tick();
    chk("busy_inj", DW'({Down_Type, Down_ChunkID, Down_ChannelID}), DW'({2'b10, 5'b10000, 10'd0}));
    chk("busy_data", Down_Data, '0);
    repeat (TO) tick();

    // Read response after 5 cycles.
    issue(1'b0, 10'd5, 32'h44, 32'h0);
    tick();
    repeat (4) tick();
    set_ret(2'b10, 5'b00001, 32'h44, 32'h12345678);
    tick();
    set_ret(2'b00, '0, '0, '0);
    chk("rd_rsp", DW'({rsp_valid, rsp_timeout, rsp_data}), DW'({2'b10, 32'h12345678}));

    // Wrong-address response ignored; timeout exactly TO cycles after injection.
    issue(1'b0, 10'd2, 32'h44, 32'h0);
    tick();
    set_ret(2'b10, 5'b00001, 32'h48, 32'h0BADF00D);
    tick();
    set_ret(2'b00, '0, '0, '0);
    n = 1;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    chk("to_cycles", DW'(n), DW'(TO));
    chk("to_rsp", DW'({rsp_valid, rsp_timeout, rsp_data}), DW'({2'b11, 32'h0}));

    // Match on the last timeout cycle wins.
    issue(1'b0, 10'd9, 32'h44, 32'h0);
    tick();
    repeat (TO - 1) tick();
    set_ret(2'b10, 5'b00001, 32'h44, 32'hCAFEF00D);
    tick();
    set_ret(2'b00, '0, '0, '0);
    chk("last_match", DW'({rsp_valid, rsp_timeout, rsp_data}), DW'({2'b10, 32'hCAFEF00D}));

    // Asynchronous reset during WAIT_RSP aborts the read silently.
    issue(1'b0, 10'd1, 32'h44, 32'h0);
    tick();
    repeat (3) tick();
    #2 rstnIn = 1'b0;
    #1;
    chk("arst_down", DW'({Down_Type, Down_ChunkID, Down_State}), '0);
    chk("arst_data", Down_Data, '0);
    chk("arst_out", DW'({rsp_valid, cmd_ready}), '0);
    repeat (2) tick();
    rstnIn = 1'b1;
    tick();
    chk("arst_ready", DW'(cmd_ready), DW'(1'b1));
    set_ret(2'b10, 5'b00001, 32'h44, 32'h77777777);
    seen = 0;
    repeat (4) begin tick(); if (rsp_valid) seen = 1; end
    set_ret(2'b00, '0, '0, '0);
    chk("late_rsp", DW'(seen), DW'(1'b0));

    // Random traffic against the model.
    repeat (500) begin
      if (!cmd_valid && ($urandom % 3 == 0)) begin
        cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_hop = CHW'($urandom);
        cmd_addr = addrs[$urandom % 3]; cmd_wdata = $urandom;
      end
      case ($urandom % 4)
        0: set_up(2'b01);
        1: set_up(2'b10);
        default: set_up(2'b00);
      endcase
      case ($urandom % 5)
        0: set_ret(2'b10, 5'b00001, addrs[$urandom % 3], $urandom);
        1: set_ret(2'b01, 5'b00001, addrs[$urandom % 3], $urandom);
        2: set_ret(2'b10, 5'b10001, addrs[$urandom % 3], $urandom);
        default: set_ret(2'b00, '0, '0, '0);
      endcase
      acc = cmd_valid && cmd_ready;
      tick();
      if (acc) cmd_valid = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
